// File: rtl/pong_score_fsm.sv
// pong_score_fsm: miss detection, scoring and serve/play/point/over sequencing for pong
module pong_score_fsm #(
  parameter int SCREEN_W     = 640,
  parameter int BALL_SIZE    = 8,
  parameter int MISS_MARGIN  = 2,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               refresh_tick,
  input  logic               start,
  input  logic [9:0]         ball_x,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               ball_freeze,
  output logic               ball_serve,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);
  localparam int CNT_W = SERVE_FRAMES > 0 ? $clog2(SERVE_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0]   LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
  state_t st, st_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [SCORE_W-1:0] s1_n, s2_n;
  logic               dir_n, win_n, serve_n, miss_l, miss_r;
  assign miss_l = ball_x <= 10'(MISS_MARGIN);
  assign miss_r = ({1'b0, ball_x} + 11'(BALL_SIZE)) >= 11'(SCREEN_W);
  assign state  = st;
  // next-state, counter and score updates; the scorer in POINT is implied by serve_dir
  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    s1_n    = score1;
    s2_n    = score2;
    dir_n   = serve_dir;
    win_n   = winner;
    serve_n = 1'b0;
    case (st)
      IDLE: if (start) begin
        st_n  = SERVE;
        cnt_n = LOAD;
      end
      SERVE: if (refresh_tick) begin
        st_n    = cnt == '0 ? PLAY : SERVE;
        serve_n = cnt == '0;
        cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
      end
      PLAY: if (refresh_tick && miss_l) begin
        st_n  = POINT;
        dir_n = 1'b0;
        s2_n  = score2 == WIN ? score2 : score2 + 1'b1;
      end else if (refresh_tick && miss_r) begin
        st_n  = POINT;
        dir_n = 1'b1;
        s1_n  = score1 == WIN ? score1 : score1 + 1'b1;
      end
      POINT: if (serve_dir ? score1 == WIN : score2 == WIN) begin
        st_n  = OVER;
        win_n = ~serve_dir;
      end else begin
        st_n  = SERVE;
        cnt_n = LOAD;
      end
      OVER: if (start) begin
        st_n  = SERVE;
        cnt_n = LOAD;
        s1_n  = '0;
        s2_n  = '0;
        win_n = 1'b0;
      end
      default: st_n = IDLE;
    endcase
  end
  // state and registered outputs; freeze and game_over are decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= IDLE;
      cnt         <= '0;
      score1      <= '0;
      score2      <= '0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
      ball_serve  <= 1'b0;
      ball_freeze <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      st          <= st_n;
      cnt         <= cnt_n;
      score1      <= s1_n;
      score2      <= s2_n;
      serve_dir   <= dir_n;
      winner      <= win_n;
      ball_serve  <= serve_n;
      ball_freeze <= st_n != PLAY;
      game_over   <= st_n == OVER;
    end
  end
endmodule

// File: tb/tb_pong_score_fsm.sv
// tb_pong_score_fsm: table-driven and sequence checks of pong scoring and phase control
module tb_pong_score_fsm;
  logic       clk = 1'b0;
  logic       reset = 1'b1, refresh_tick = 1'b0, start = 1'b0;
  logic [9:0] ball_x = '0;
  logic [3:0] score1, score2;
  logic       ball_freeze, ball_serve, serve_dir, game_over, winner;
  logic [2:0] state;
  logic [15:0] obs;
  int checks = 0, failures = 0;
  typedef struct {
    logic       r, s, t;
    logic [9:0] x;
    logic [15:0] e;
  } vec_t;
  vec_t tbl[$];
  pong_score_fsm #(.WIN_SCORE(2), .SERVE_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start(start), .ball_x(ball_x),
    .score1(score1), .score2(score2), .ball_freeze(ball_freeze), .ball_serve(ball_serve),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner), .state(state)
  );
  assign obs = {state, score1, score2, ball_freeze, ball_serve, serve_dir, game_over, winner};
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic t, input logic [9:0] x);
    reset = r;
    start = s;
    refresh_tick = t;
    ball_x = x;
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic r, s, t, input int x, input int st, a, b, input logic f, v, d, o, w);
    tbl.push_back('{r, s, t, 10'(x), {3'(st), 4'(a), 4'(b), f, v, d, o, w}});
  endtask
  initial begin
    int pulses, pc, bad;
    //  r  s  t  x     st a  b  frz srv dir ovr win
    add(1, 0, 0, 0,    0, 0, 0, 1,  0,  0,  0,  0);
    add(0, 0, 0, 0,    0, 0, 0, 1,  0,  0,  0,  0);
    add(0, 0, 1, 0,    0, 0, 0, 1,  0,  0,  0,  0);
    add(0, 1, 1, 0,    1, 0, 0, 1,  0,  0,  0,  0);
    add(0, 0, 1, 0,    1, 0, 0, 1,  0,  0,  0,  0);
    add(0, 0, 1, 0,    1, 0, 0, 1,  0,  0,  0,  0);
    add(0, 0, 1, 0,    1, 0, 0, 1,  0,  0,  0,  0);
    add(0, 1, 0, 0,    1, 0, 0, 1,  0,  0,  0,  0);
    add(0, 0, 1, 320,  2, 0, 0, 0,  1,  0,  0,  0);
    add(0, 0, 0, 1,    2, 0, 0, 0,  0,  0,  0,  0);
    add(0, 0, 1, 1,    3, 0, 1, 1,  0,  0,  0,  0);
    add(0, 0, 0, 1,    1, 0, 1, 1,  0,  0,  0,  0);
    add(0, 0, 1, 1,    1, 0, 1, 1,  0,  0,  0,  0);
    add(0, 0, 1, 1,    1, 0, 1, 1,  0,  0,  0,  0);
    add(0, 0, 1, 1,    1, 0, 1, 1,  0,  0,  0,  0);
    add(0, 0, 1, 320,  2, 0, 1, 0,  1,  0,  0,  0);
    add(0, 0, 1, 631,  2, 0, 1, 0,  0,  0,  0,  0);
    add(0, 0, 1, 632,  3, 1, 1, 1,  0,  1,  0,  0);
    add(0, 0, 0, 632,  1, 1, 1, 1,  0,  1,  0,  0);
    add(0, 0, 1, 0,    1, 1, 1, 1,  0,  1,  0,  0);
    add(0, 0, 1, 0,    1, 1, 1, 1,  0,  1,  0,  0);
    add(0, 0, 1, 0,    1, 1, 1, 1,  0,  1,  0,  0);
    add(0, 0, 1, 320,  2, 1, 1, 0,  1,  1,  0,  0);
    add(0, 1, 1, 1023, 3, 2, 1, 1,  0,  1,  0,  0);
    add(0, 0, 0, 0,    4, 2, 1, 1,  0,  1,  1,  0);
    add(0, 0, 1, 0,    4, 2, 1, 1,  0,  1,  1,  0);
    add(0, 0, 1, 0,    4, 2, 1, 1,  0,  1,  1,  0);
    add(0, 1, 1, 0,    1, 0, 0, 1,  0,  1,  0,  0);
    add(0, 0, 1, 0,    1, 0, 0, 1,  0,  1,  0,  0);
    add(1, 0, 1, 0,    0, 0, 0, 1,  0,  0,  0,  0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].t, tbl[i].x);
      chk($sformatf("vec%0d", i), 32'(obs), 32'(tbl[i].e));
    end
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      step(0, 0, c[0], 0);
      if (ball_serve || state != 3'd0) bad++;
    end
    chk("post_reset_quiet", 32'(bad), 0);
    step(1, 0, 0, 320);
    pulses = 0;
    pc = 0;
    for (int c = 1; c <= 45; c++) begin
      step(0, c == 5, c % 10 == 0, 320);
      if (ball_serve) begin
        pulses++;
        pc = c;
      end
      if (c == 39) chk("serve_before_4th_tick", 32'(state), 1);
      if (c == 40) chk("play_at_4th_tick", 32'({state, ball_freeze}), 32'({3'd2, 1'b0}));
    end
    chk("serve_pulse_count", 32'(pulses), 1);
    chk("serve_pulse_cycle", 32'(pc), 40);
    step(0, 0, 1, 0);
    chk("left_miss_x0", 32'({state, score2, serve_dir}), 32'({3'd3, 4'd1, 1'b0}));
    step(0, 0, 0, 0);
    chk("point_to_serve", 32'(state), 1);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 320);
    chk("second_serve_play", 32'(state), 2);
    step(0, 0, 1, 2);
    chk("left_miss_margin", 32'({state, score2}), 32'({3'd3, 4'd2}));
    step(0, 0, 0, 2);
    chk("right_wins", 32'({state, game_over, winner, score1, score2}), 32'({3'd4, 1'b1, 1'b1, 4'd0, 4'd2}));
    step(0, 0, 1, 639);
    step(0, 0, 1, 0);
    chk("over_frozen", 32'({state, score1, score2}), 32'({3'd4, 4'd0, 4'd2}));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
